flit_output_arbiter: RTL and testbench

FLIT_OUTPUT_ARBITER -- requirements
Module: flit_output_arbiter

---
 rtl/flit_output_arbiter.sv | 126 ++++++++++++
 tb/tb_flit_output_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/flit_output_arbiter.sv
// Purpose: 4-queue round-robin flit arbiter with packet lock and credit-based downstream flow control.
// Latency: 1 cycle from q_deq strobe to registered out_valid/out_data.
// Backpressure: no dequeue while credits are exhausted or while the locked owner queue is empty.
// Optional FLIT_ARB_STATS_EN adds flits_sent / pkts_sent counters.
module flit_output_arbiter #(
    parameter int CREDITS = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [3:0]   q_not_empty,
    input  logic [131:0] q_data_0,
    input  logic [131:0] q_data_1,
    input  logic [131:0] q_data_2,
    input  logic [131:0] q_data_3,
    output logic [3:0]   q_deq,
    output logic         out_valid,
    output logic [131:0] out_data,
    input  logic         credit_in,
    output logic         credit_err,
    output logic         locked
`ifdef FLIT_ARB_STATS_EN
    ,
    output logic [15:0]  flits_sent,
    output logic [15:0]  pkts_sent
`endif
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   rr;
    logic [1:0]   owner;
    logic [1:0]   grant;
    logic [3:0]   cred;
    logic         any_elig;
    logic         send;
    logic         tail;
    logic [131:0] sel_dat;

    // Lowest offset from rr wins, so iterate from the far end and let nearer hits overwrite.
    always_comb begin
        grant    = rr;
        any_elig = 1'b0;
        if (state == LOCKED) begin
            grant    = owner;
            any_elig = q_not_empty[owner];
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (q_not_empty[rr + 2'(i)]) begin
                    grant    = rr + 2'(i);
                    any_elig = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (grant)
            2'd0:    sel_dat = q_data_0;
            2'd1:    sel_dat = q_data_1;
            2'd2:    sel_dat = q_data_2;
            default: sel_dat = q_data_3;
        endcase
    end

    assign tail = sel_dat[128];
    assign send = RST_N && (cred != 4'd0) && any_elig;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (send && !tail) state_nxt = LOCKED;
            LOCKED:  if (send && tail)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_deq  = send ? (4'b0001 << grant) : 4'b0000;
        locked = (state == LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr         <= 2'd0;
            owner      <= 2'd0;
            cred       <= CRED_MAX;
            out_valid  <= 1'b0;
            out_data   <= '0;
            credit_err <= 1'b0;
        end else begin
            out_valid <= send;
            if (send)                                out_data <= sel_dat;
            if (send && tail)                        rr       <= grant + 2'd1;
            if (state == IDLE && send && !tail)      owner    <= grant;
            // A returned credit with the counter already full means downstream miscounted.
            if (send && !credit_in) begin
                cred <= cred - 4'd1;
            end else if (!send && credit_in) begin
                if (cred == CRED_MAX) credit_err <= 1'b1;
                else                  cred       <= cred + 4'd1;
            end
        end
    end

`ifdef FLIT_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            flits_sent <= 16'd0;
            pkts_sent  <= 16'd0;
        end else begin
            if (send)         flits_sent <= flits_sent + 16'd1;
            if (send && tail) pkts_sent  <= pkts_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flit_output_arbiter.sv
// Directed bench for flit_output_arbiter: fairness, packet lock, lock stall, credits, overflow, reset mid-packet.
module tb_flit_output_arbiter;

    logic         CLK;
    logic         RST_N;
    logic [3:0]   q_not_empty;
    logic [3:0]   tl;
    logic [127:0] pl [4];
    logic [131:0] q_data_0, q_data_1, q_data_2, q_data_3;
    logic [3:0]   q_deq;
    logic         out_valid;
    logic [131:0] out_data;
    logic         credit_in;
    logic         credit_err;
    logic         locked;

    int           total;
    int           bad;
    logic         exp_err;
    logic [131:0] last_dat;

    assign q_data_0 = {3'b000, tl[0], pl[0]};
    assign q_data_1 = {3'b000, tl[1], pl[1]};
    assign q_data_2 = {3'b000, tl[2], pl[2]};
    assign q_data_3 = {3'b000, tl[3], pl[3]};

    flit_output_arbiter #(.CREDITS(8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .q_not_empty (q_not_empty),
        .q_data_0    (q_data_0),
        .q_data_1    (q_data_1),
        .q_data_2    (q_data_2),
        .q_data_3    (q_data_3),
        .q_deq       (q_deq),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .credit_in   (credit_in),
        .credit_err  (credit_err),
        .locked      (locked)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: strobe/lock checked mid-cycle, registered outputs just after the edge.
    task automatic step(input string tag, input logic [3:0] exp_deq, input logic exp_lock);
        logic [131:0] exp_dat;
        @(negedge CLK);
        chk({tag, ".deq"},  132'(q_deq),  132'(exp_deq));
        chk({tag, ".lock"}, 132'(locked), 132'(exp_lock));
        exp_dat = last_dat;
        for (int i = 0; i < 4; i++)
            if (exp_deq[i]) exp_dat = {3'b000, tl[i], pl[i]};
        if (!RST_N) exp_dat = '0;
        @(posedge CLK);
        #1;
        chk({tag, ".vld"},  132'(out_valid),  132'(exp_deq != 4'd0));
        chk({tag, ".dat"},  out_data,         exp_dat);
        chk({tag, ".err"},  132'(credit_err), 132'(exp_err));
        last_dat = exp_dat;
        for (int i = 0; i < 4; i++) pl[i] = pl[i] + 128'd1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        exp_err     = 1'b0;
        last_dat    = '0;
        RST_N       = 1'b0;
        credit_in   = 1'b0;
        q_not_empty = 4'hF;
        tl          = 4'hF;
        for (int i = 0; i < 4; i++) pl[i] = 128'(i + 1) << 64;
        #1;

        // reset: dequeue suppressed, registers cleared
        step("rst_a", 4'b0000, 1'b0);
        step("rst_b", 4'b0000, 1'b0);
        RST_N = 1'b1;

        // single-flit fairness: 0,1,2,3,0
        step("fair0", 4'b0001, 1'b0);
        step("fair1", 4'b0010, 1'b0);
        step("fair2", 4'b0100, 1'b0);
        step("fair3", 4'b1000, 1'b0);
        step("fair4", 4'b0001, 1'b0);
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        repeat (5) step("refill_a", 4'b0000, 1'b0);
        credit_in = 1'b0;

        // packet lock on queue 1 (rr=1), queue 2 waiting
        q_not_empty = 4'b0110;
        tl          = 4'b0100;
        step("pkt0", 4'b0010, 1'b0);
        step("pkt1", 4'b0010, 1'b1);
        tl[1] = 1'b1;
        step("pkt2", 4'b0010, 1'b1);
        step("pkt3", 4'b0100, 1'b0);
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        repeat (4) step("refill_b", 4'b0000, 1'b0);
        credit_in = 1'b0;

        // lock stall: owner 1 empty while queue 0 waits (rr=3)
        tl          = 4'b1101;
        q_not_empty = 4'b0010;
        step("stall0", 4'b0010, 1'b0);
        q_not_empty = 4'b0001;
        repeat (4) step("stall_hold", 4'b0000, 1'b1);
        q_not_empty = 4'b0011;
        tl[1] = 1'b1;
        step("stall_resume", 4'b0010, 1'b1);
        step("stall_next", 4'b0001, 1'b0);
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        repeat (3) step("refill_c", 4'b0000, 1'b0);
        credit_in = 1'b0;

        // credit exhaustion: 8 sends then stall
        q_not_empty = 4'b0001;
        repeat (8) step("cred_send", 4'b0001, 1'b0);
        repeat (2) step("cred_stall", 4'b0000, 1'b0);
        credit_in = 1'b1;
        step("cred_zero_in", 4'b0000, 1'b0);
        credit_in = 1'b0;
        step("cred_one", 4'b0001, 1'b0);
        step("cred_out", 4'b0000, 1'b0);

        // send plus credit_in together leaves cred unchanged
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        step("sim_give", 4'b0000, 1'b0);
        q_not_empty = 4'b0001;
        step("sim_both", 4'b0001, 1'b0);
        credit_in = 1'b0;
        step("sim_last", 4'b0001, 1'b0);
        step("sim_empty", 4'b0000, 1'b0);

        // overflow: credit at full sets sticky error, cred stays 8
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        repeat (8) step("ovf_fill", 4'b0000, 1'b0);
        exp_err = 1'b1;
        step("ovf_hit", 4'b0000, 1'b0);
        credit_in   = 1'b0;
        q_not_empty = 4'b0001;
        repeat (8) step("ovf_send", 4'b0001, 1'b0);
        step("ovf_stall", 4'b0000, 1'b0);

        // reset mid-packet on queue 3
        q_not_empty = 4'h0;
        credit_in   = 1'b1;
        repeat (8) step("refill_d", 4'b0000, 1'b0);
        credit_in   = 1'b0;
        tl          = 4'b0111;
        q_not_empty = 4'b1000;
        step("lk3_a", 4'b1000, 1'b0);
        step("lk3_b", 4'b1000, 1'b1);
        q_not_empty = 4'b1001;
        RST_N   = 1'b0;
        exp_err = 1'b0;
        step("rst_mid", 4'b0000, 1'b1);
        RST_N = 1'b1;
        step("post_rst0", 4'b0001, 1'b0);
        q_not_empty = 4'b0001;
        repeat (7) step("post_rst_send", 4'b0001, 1'b0);
        step("post_rst_stall", 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
